spi_master_tx: RTL and testbench

- Byte-oriented SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first.
- Drives sclk, mosi and cs toward the FPGA-side SPI slave, and samples miso from it.
- Sits in the bench/host side of the SPI_FPGA design; also reusable to drive an external slave from a system-level controller.
- Simple start/rdy handshake on the user side.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_master_tx_if.sv | 30 +++
 rtl/spi_tick_gen.sv | 37 +++
 rtl/spi_master_tx.sv | 159 +++++++++++++++
 tb/tb_spi_master_tx.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and default constants for the SPI mode-0 transmit master.
package spi_pkg;

   localparam int unsigned SPI_DATA_W   = 8;
   localparam int unsigned SPI_CLK_DIV  = 4;
   localparam int unsigned SPI_SLOW_DIV = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } spi_state_t;

   // Larger of two divider values, used to size the half-period counter.
   function automatic int unsigned max_div(int unsigned a, int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// User-side start/rdy handshake bundle for spi_master_tx.
// The speed signal exists only when SPI_SPEED_SEL_EN is defined.
interface spi_master_tx_if
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W = SPI_DATA_W
);

   logic              start;
   logic [DATA_W-1:0] tx_data;
`ifdef SPI_SPEED_SEL_EN
   logic              speed;
`endif
   logic [DATA_W-1:0] rx_data;
   logic              rdy;
   logic              busy;

`ifdef SPI_SPEED_SEL_EN
   modport master (output start, output tx_data, output speed,
                   input rx_data, input rdy, input busy);
   modport slave  (input start, input tx_data, input speed,
                   output rx_data, output rdy, output busy);
`else
   modport master (output start, output tx_data,
                   input rx_data, input rdy, input busy);
   modport slave  (input start, input tx_data,
                   output rx_data, output rdy, output busy);
`endif

endinterface

// File: rtl/spi_tick_gen.sv
// Loadable down-counter: one-cycle tick every div cycles while enabled.
// The count restarts from div whenever enable rises.
module spi_tick_gen #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [CNT_W-1:0] div,
   output logic             tick
);

   logic [CNT_W-1:0] cnt_q, cnt_d, cur;
   logic             en_q;

   // Reload on enable rise, tick at zero, reload after each tick.
   always_comb begin
      cur   = (enable && !en_q) ? (div - CNT_W'(1)) : cnt_q;
      tick  = enable && (cur == '0);
      cnt_d = '0;
      if (enable) begin
         cnt_d = tick ? (div - CNT_W'(1)) : (cur - CNT_W'(1));
      end
   end

   // Counter and enable-edge history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         en_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         en_q  <= enable;
      end
   end

endmodule

// File: rtl/spi_master_tx.sv
// Byte-oriented SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first.
// Optional macro SPI_SPEED_SEL_EN adds a per-transfer fast/slow rate select.
module spi_master_tx
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W   = SPI_DATA_W,
   parameter int unsigned CLK_DIV  = SPI_CLK_DIV,
   parameter int unsigned SLOW_DIV = SPI_SLOW_DIV
) (
   input  logic                  clk,
   input  logic                  rst,
   spi_master_tx_if.slave        bus,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   output logic                  cs
);

   localparam int unsigned DIV_W = $clog2(max_div(CLK_DIV, SLOW_DIV) + 1);
   localparam int unsigned BIT_W = $clog2(DATA_W) + 1;

   spi_state_t        state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d, sel_div;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rdy_q, rdy_d;
   logic              busy_q, busy_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              cs_q, cs_d;
   logic              tick;
   logic              rise;

   // Half-period chosen at start acceptance.
`ifdef SPI_SPEED_SEL_EN
   always_comb sel_div = bus.speed ? DIV_W'(CLK_DIV) : DIV_W'(SLOW_DIV);
`else
   always_comb sel_div = DIV_W'(CLK_DIV);
`endif

   spi_tick_gen #(
      .CNT_W (DIV_W)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .enable (state_q != IDLE),
      .div    (div_q),
      .tick   (tick)
   );

   // Transfer sequencing: setup, 2*DATA_W half-periods, hold, release.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      bit_cnt_d = bit_cnt_q;
      rx_data_d = rx_data_q;
      rdy_d     = 1'b0;
      busy_d    = busy_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_d      = cs_q;
      rise      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               tx_sh_d   = bus.tx_data;
               rx_sh_d   = '0;
               bit_cnt_d = '0;
               div_d     = sel_div;
               cs_d      = 1'b0;
               mosi_d    = bus.tx_data[DATA_W-1];
               busy_d    = 1'b1;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            if (tick) begin
               rise    = 1'b1;
               state_d = XFER;
            end
         end
         XFER: begin
            if (tick) begin
               if (sclk_q) begin
                  sclk_d = 1'b0;
                  // Last falling edge leaves the LSB on mosi.
                  if (bit_cnt_q != BIT_W'(DATA_W)) begin
                     mosi_d  = tx_sh_q[DATA_W-2];
                     tx_sh_d = tx_sh_q << 1;
                  end
               end else if (bit_cnt_q == BIT_W'(DATA_W)) begin
                  // Trailing low half-period done.
                  state_d = HOLD;
               end else begin
                  rise = 1'b1;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               cs_d      = 1'b1;
               rx_data_d = rx_sh_q;
               rdy_d     = 1'b1;
               busy_d    = 1'b0;
               mosi_d    = 1'b0;
               bit_cnt_d = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rise) begin
         sclk_d    = 1'b1;
         rx_sh_d   = {rx_sh_q[DATA_W-2:0], miso};
         bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
   end

   // State and registered outputs; reset never publishes partial data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         div_q     <= '0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         bit_cnt_q <= '0;
         rx_data_q <= '0;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         bit_cnt_q <= bit_cnt_d;
         rx_data_q <= rx_data_d;
         rdy_q     <= rdy_d;
         busy_q    <= busy_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_q      <= cs_d;
      end
   end

   assign bus.rx_data = rx_data_q;
   assign bus.rdy     = rdy_q;
   assign bus.busy    = busy_q;
   assign sclk        = sclk_q;
   assign mosi        = mosi_q;
   assign cs          = cs_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: vector table, random transfers against a
// frame-level model, and hand sequences for ignore/reset/back-to-back.
// Exercises the slow rate when SPI_SPEED_SEL_EN is defined.
module tb_spi_master_tx;
   import spi_pkg::*;

   localparam int unsigned DW   = 8;
   localparam int unsigned FAST = 4;
   localparam int unsigned SLOW = 16;

   typedef struct {
      logic [DW-1:0] tx;
      bit            loop;
      logic [DW-1:0] pat;
      logic [DW-1:0] exp_rx;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          sclk, mosi, miso, cs;
   bit            loop_en = 1'b0;
   logic          miso_pat = 1'b0;
   logic          speed_sel = 1'b1;
   int            checks = 0;
   int            errors = 0;
   vec_t          vecs[5];

   spi_master_tx_if #(.DATA_W(DW)) bus ();

   spi_master_tx #(
      .DATA_W   (DW),
      .CLK_DIV  (FAST),
      .SLOW_DIV (SLOW)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .sclk (sclk),
      .mosi (mosi),
      .miso (miso),
      .cs   (cs)
   );

`ifdef SPI_SPEED_SEL_EN
   assign bus.speed = speed_sel;
`endif

   assign miso = loop_en ? mosi : miso_pat;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Frame-level model: what the slave presented on miso, MSB first.
   function automatic logic [DW-1:0] model_rx(input logic [DW-1:0] tx, input bit loop,
                                              input logic [DW-1:0] pat);
      return loop ? tx : pat;
   endfunction

   // One full transfer, observed at negedges; poke_at re-pulses start,
   // toggle_at flips the rate select mid-transfer.
   task automatic run_xfer(input string tag, input logic [DW-1:0] tx, input bit loop,
                           input logic [DW-1:0] pat, input logic [DW-1:0] exp_rx,
                           input int div, input int poke_at, input int toggle_at);
      int            rises;
      int            cs_low;
      int            busy_bad;
      int            rdy_bad;
      bit            rdy_seen;
      logic          prev_sclk;
      logic [DW-1:0] mosi_seen;
      rises     = 0;
      cs_low    = 0;
      busy_bad  = 0;
      rdy_bad   = 0;
      rdy_seen  = 1'b0;
      prev_sclk = 1'b0;
      mosi_seen = '0;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.tx_data = tx;
      loop_en     = loop;
      miso_pat    = pat[DW-1];
      for (int cyc = 0; cyc < 4000 && !rdy_seen; cyc++) begin
         @(negedge clk);
         if (cyc == 0) bus.start = 1'b0;
         if (cyc == poke_at) begin
            bus.start   = 1'b1;
            bus.tx_data = '0;
         end else if (cyc == poke_at + 1) begin
            bus.start = 1'b0;
         end
         if (cyc == toggle_at) speed_sel = ~speed_sel;
         if (sclk && !prev_sclk) begin
            mosi_seen = {mosi_seen[DW-2:0], mosi};
            rises++;
         end
         prev_sclk = sclk;
         if (rises < DW) miso_pat = pat[DW-1-rises];
         if (!cs) begin
            cs_low++;
            if (!bus.busy) busy_bad++;
         end
         if (bus.rdy) begin
            rdy_seen = 1'b1;
            check({tag, "_rx"}, bus.rx_data, exp_rx);
            check({tag, "_cs_at_rdy"}, cs, 1);
            check({tag, "_busy_at_rdy"}, bus.busy, 0);
            check({tag, "_mosi_idle"}, mosi, 0);
         end else if (!cs && bus.rdy) begin
            rdy_bad++;
         end
      end
      if (!rdy_seen) check({tag, "_timeout"}, 0, 1);
      check({tag, "_cs_low"}, cs_low, div + 2 * DW * div + div);
      check({tag, "_rises"}, rises, DW);
      check({tag, "_mosi_bits"}, mosi_seen, tx);
      check({tag, "_busy_held"}, busy_bad + rdy_bad, 0);
      @(negedge clk);
      check({tag, "_rdy_width"}, bus.rdy, 0);
      check({tag, "_rx_hold"}, bus.rx_data, exp_rx);
   endtask

   initial begin
      logic [DW-1:0] r_tx, r_pat;
      bit            r_loop;
      int            extra_rdy;
      int            n_done;
      bit            gap_pending;

      bus.start   = 1'b0;
      bus.tx_data = '0;
      rst         = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("reset_cs", cs, 1);
      check("reset_sclk", sclk, 0);
      check("reset_mosi", mosi, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_rdy", bus.rdy, 0);
      check("reset_rx", bus.rx_data, 0);
      @(negedge clk);
      rst = 1'b1;

      vecs[0] = '{tx: 8'hA5, loop: 1'b1, pat: 8'h00, exp_rx: 8'hA5};
      vecs[1] = '{tx: 8'h3C, loop: 1'b0, pat: 8'hFF, exp_rx: 8'hFF};
      vecs[2] = '{tx: 8'h00, loop: 1'b0, pat: 8'h00, exp_rx: 8'h00};
      vecs[3] = '{tx: 8'hFF, loop: 1'b1, pat: 8'h00, exp_rx: 8'hFF};
      vecs[4] = '{tx: 8'h5A, loop: 1'b0, pat: 8'hA5, exp_rx: 8'hA5};
      for (int i = 0; i < 5; i++) begin
         run_xfer($sformatf("vec%0d", i), vecs[i].tx, vecs[i].loop, vecs[i].pat,
                  vecs[i].exp_rx, FAST, -1, -1);
      end

      for (int i = 0; i < 6; i++) begin
         r_tx   = DW'($urandom);
         r_pat  = DW'($urandom);
         r_loop = 1'($urandom_range(0, 1));
         run_xfer($sformatf("rand%0d", i), r_tx, r_loop, r_pat,
                  model_rx(r_tx, r_loop, r_pat), FAST, -1, -1);
      end

      // start while busy must not disturb or restart the transfer.
      run_xfer("ignore", 8'hA5, 1'b1, 8'h00, 8'hA5, FAST, 20, -1);
      extra_rdy = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.rdy || !cs) extra_rdy++;
      end
      check("ignore_no_second_xfer", extra_rdy, 0);

      // Asynchronous reset in the middle of the bit phase.
      @(negedge clk);
      bus.start   = 1'b1;
      bus.tx_data = 8'hC3;
      loop_en     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (29) @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_cs", cs, 1);
      check("midrst_sclk", sclk, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_rdy", bus.rdy, 0);
      check("midrst_rx", bus.rx_data, 0);
      @(negedge clk);
      rst = 1'b1;
      run_xfer("post_rst", 8'h5A, 1'b1, 8'h00, 8'h5A, FAST, -1, -1);

      // start held high: one idle cycle of cs between frames.
      @(negedge clk);
      bus.tx_data = 8'h81;
      loop_en     = 1'b1;
      bus.start   = 1'b1;
      n_done      = 0;
      gap_pending = 1'b0;
      for (int cyc = 0; cyc < 1000 && n_done < 3; cyc++) begin
         @(negedge clk);
         if (gap_pending) begin
            check("b2b_gap", cs, 0);
            gap_pending = 1'b0;
         end
         if (bus.rdy) begin
            check("b2b_rx", bus.rx_data, 8'h81);
            check("b2b_cs_high", cs, 1);
            n_done++;
            if (n_done < 3) gap_pending = 1'b1;
            else bus.start = 1'b0;
         end
      end
      check("b2b_count", n_done, 3);
      repeat (3) @(negedge clk);

`ifdef SPI_SPEED_SEL_EN
      speed_sel = 1'b0;
      run_xfer("slow", 8'hC3, 1'b1, 8'h00, 8'hC3, SLOW, -1, 100);
      speed_sel = 1'b1;
      run_xfer("fast_again", 8'h3C, 1'b1, 8'h00, 8'h3C, FAST, -1, -1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
